// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the flappy-bird datapath: button conditioning,
// hit/pass merging, IDLE/RUN/HIT/OVER sequencing with lives, score and high score.
module game_flow_ctrl #(
    parameter int N_CH        = 2,
    parameter int SCORE_W     = 10,
    parameter int LIVES       = 1,
    parameter int LIVES_W     = 3,
    parameter int DEBOUNCE    = 4,
    parameter int FLASH_TICKS = 32
) (
    input  logic               gameClk,
    input  logic               reset_n,
    input  logic               btn,
    input  logic [N_CH-1:0]    hit,
    input  logic [N_CH-1:0]    pass,
    output logic               flap,
    output logic               run,
    output logic               respawn,
    output logic               finished,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HIT  = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int FL_W  = $clog2(FLASH_TICKS + 1);
    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = SCORE_W + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic [1:0]       sync;
    logic             db;
    logic             db_q;
    logic [CNT_W-1:0] db_cnt;
    logic             press;
    logic [FL_W-1:0]  flash_cnt;
    logic [PC_W-1:0]  pass_cnt;
    logic [SUM_W-1:0] score_sum;
    logic [SCORE_W-1:0] score_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain the synchroniser into one stage.
    always_ff @(posedge gameClk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= 2'b00;
            db     <= 1'b0;
            db_q   <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] != db) begin
                if (db_cnt == CNT_W'(DEBOUNCE - 1)) begin
                    db     <= sync[1];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            db_q  <= db;
            press <= db & ~db_q;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            pass_cnt = pass_cnt + PC_W'(pass[i]);
        end
        score_sum  = {1'b0, score} + SUM_W'(pass_cnt);
        score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge gameClk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            flap       <= 1'b0;
            run        <= 1'b0;
            respawn    <= 1'b0;
            finished   <= 1'b0;
            score      <= '0;
            high_score <= '0;
            lives      <= LIVES_W'(LIVES);
            flash_cnt  <= '0;
        end else begin
            flap    <= 1'b0;
            respawn <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (press) begin
                        state <= S_RUN;
                        run   <= 1'b1;
                        flap  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (press) flap <= 1'b1;
                    // A hit in the same cycle as a pass pulse drops the pass.
                    if (|hit) begin
                        state     <= S_HIT;
                        run       <= 1'b0;
                        lives     <= lives - 1'b1;
                        flash_cnt <= '0;
                    end else begin
                        score <= score_next;
                    end
                end
                S_HIT: begin
                    if (flash_cnt == FL_W'(FLASH_TICKS - 1)) begin
                        flash_cnt <= '0;
                        if (lives == '0) begin
                            state    <= S_OVER;
                            finished <= 1'b1;
                            if (score > high_score) high_score <= score;
                        end else begin
                            state   <= S_RUN;
                            run     <= 1'b1;
                            respawn <= 1'b1;
                        end
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                S_OVER: begin
                    if (press) begin
                        state    <= S_IDLE;
                        finished <= 1'b0;
                        score    <= '0;
                        lives    <= LIVES_W'(LIVES);
                        respawn  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
